cpu_memory_stage: RTL and testbench
===================================

Name: cpu_memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its registered result bundle on a strobe-toggle handshake.
- Non-memory results pass through to writeback in one cycle.
- Loads, stores and flushes run on a single-outstanding data bus with byte enables, load sign/zero extension and a bus timeout.
- Drives the busy back-pressure that stalls execute.

Parameters:
TIMEOUT, 1023, bus wait cycles before fault; 0 disables timeout.

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_strobe  in  1  execute strobe; toggle marks a new operation
i_inst_rd  in  5  destination register for non-load ops (0 = none)
i_rd  in  32  ALU result, or store data for stores
i_mem_read  in  1  load
i_mem_write  in  1  store
i_mem_flush  in  1  cache flush request
i_mem_width  in  2  0 byte, 1 half, 2 word (3 illegal)
i_mem_signed  in  1  sign-extend load
i_mem_address  in  32  effective address
i_mem_inst_rd  in  5  load destination register
o_busy  out  1  stall to execute (its memory-busy input)
o_bus_request  out  1  bus cycle active
o_bus_rw  out  1  1 = write
o_bus_flush  out  1  flush cycle
o_bus_address  out  32  word-aligned address
o_bus_wdata  out  32  lane-replicated store data
o_bus_wmask  out  4  byte enables
i_bus_rdata  in  32  read data
i_bus_ready  in  1  one-cycle completion
o_wb_strobe  out  1  toggles per retired result
o_wb_inst_rd  out  5  writeback register
o_wb_rd  out  32  writeback value
o_fault  out  1  sticky fault

Behaviour:
- Reset: all outputs 0; last_strobe = 0; state IDLE; timeout counter 0. Reset mid-transaction aborts immediately: o_bus_request drops next edge with no writeback.
- New op: i_strobe != last_strobe while in IDLE.
- o_busy (comb) = (state != IDLE) || (new op && (i_mem_read || i_mem_write || i_mem_flush)).
- Pass-through (no mem flag): next edge sets o_wb_rd = i_rd, o_wb_inst_rd = i_inst_rd, toggles o_wb_strobe, updates last_strobe. Latency 1 cycle; o_busy stays low.
- Memory op: latch all inputs at the first edge, then enter READ, WRITE or FLUSH.
  - Priority when flags coincide: flush > write > read.
  - Assert o_bus_request and the corresponding rw/flush.
  - o_bus_address = {addr[31:2], 2'b00}.
- Store data and masks:
  - Byte: wdata = {4{d[7:0]}}, wmask = 1 << addr[1:0].
  - Half: wdata = {2{d[15:0]}}, wmask = addr[1] ? 1100 : 0011.
  - Word: wmask = 1111.
- Wait: hold the request and all bus outputs stable until i_bus_ready.
  - In the i_bus_ready cycle, request drops on the next edge and the state returns to IDLE.
  - Load: writes back o_wb_inst_rd = latched mem_inst_rd and toggles o_wb_strobe.
  - Store/flush: update last_strobe only; no writeback toggle.
- Load extraction: select byte addr[1:0] or half addr[1]; sign- or zero-extend per mem_signed.
- Latency: load retires in bus wait + 1 cycles; o_busy deasserts the cycle after i_bus_ready.
- Misalignment fault (half with addr[0]=1, word with addr[1:0]≠0, or width 3):
  - No bus request; o_fault = 1 sticky until reset.
  - Op consumed (last_strobe updated), no writeback.
- Timeout: counter increments each waiting cycle. Reaching TIMEOUT sets o_fault, drops the request and returns to IDLE with no writeback. A late i_bus_ready in IDLE is ignored.
- i_strobe toggling again while busy is illegal upstream; it is ignored until IDLE.
- i_bus_ready while IDLE: ignored.

Test Plan:
- Pass-through: toggle strobe with no mem flags, i_inst_rd=5, i_rd=0x1234 -> next cycle o_wb_inst_rd=5, o_wb_rd=0x1234, o_wb_strobe toggled, o_busy never high.
- Signed byte load: addr 0x103, rdata 0x80FFFFFF, ready after 3 cycles -> o_bus_address 0x100, o_wb_rd=0xFFFFFF80, o_busy high 4 cycles.
- Half store: addr 0x202, data 0xABCD -> wdata 0xABCDABCD, wmask 1100, rw=1, no wb_strobe toggle.
- Misaligned word load at 0x301 -> no o_bus_request, o_fault=1, held after further ops until i_reset.
- Timeout TIMEOUT=4, ready never asserted -> request drops after 4 wait cycles, o_fault=1, state IDLE.
- Reset during load wait -> next edge request=0, o_busy=0, o_wb_strobe=0; a later ready pulse is ignored.

Source files
------------

// File: rtl/cpu_memory_stage_if.sv
// Data bus between the memory stage (master) and the memory system (slave).
// Signal names are taken from the stage's point of view.
interface cpu_memory_stage_if;
  logic        o_bus_request;
  logic        o_bus_rw;
  logic        o_bus_flush;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_wmask;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ready;

  modport master (
    output o_bus_request, o_bus_rw, o_bus_flush, o_bus_address, o_bus_wdata, o_bus_wmask,
    input  i_bus_rdata, i_bus_ready
  );

  modport slave (
    input  o_bus_request, o_bus_rw, o_bus_flush, o_bus_address, o_bus_wdata, o_bus_wmask,
    output i_bus_rdata, i_bus_ready
  );
endinterface

// File: rtl/cpu_memory_stage.sv
// Memory pipeline stage: passes ALU results to writeback, runs loads,
// stores and flushes on a single-outstanding data bus, stalls execute.
module cpu_memory_stage #(
  parameter int TIMEOUT = 1023
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_strobe,
  input  logic [4:0]  i_inst_rd,
  input  logic [31:0] i_rd,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_mem_flush,
  input  logic [1:0]  i_mem_width,
  input  logic        i_mem_signed,
  input  logic [31:0] i_mem_address,
  input  logic [4:0]  i_mem_inst_rd,
  output logic        o_busy,
  cpu_memory_stage_if.master bus,
  output logic        o_wb_strobe,
  output logic [4:0]  o_wb_inst_rd,
  output logic [31:0] o_wb_rd,
  output logic        o_fault
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_FLUSH} state_t;

  state_t      r_state,       w_state;
  logic        r_last_strobe, w_last_strobe;
  logic        r_op_strobe,   w_op_strobe;
  logic [1:0]  r_addr_lo,     w_addr_lo;
  logic [1:0]  r_width,       w_width;
  logic        r_signed,      w_signed;
  logic [4:0]  r_ld_rd,       w_ld_rd;
  logic [31:0] r_timer,       w_timer;
  logic        r_req,         w_req;
  logic        r_rw,          w_rw;
  logic        r_flush,       w_flush;
  logic [31:0] r_bus_addr,    w_bus_addr;
  logic [31:0] r_wdata,       w_wdata;
  logic [3:0]  r_wmask,       w_wmask;
  logic        r_wb_strobe,   w_wb_strobe;
  logic [4:0]  r_wb_inst_rd,  w_wb_inst_rd;
  logic [31:0] r_wb_rd,       w_wb_rd;
  logic        r_fault,       w_fault;

  logic        w_new_op;
  logic        w_mem_op;
  logic        w_misalign;
  logic [31:0] w_st_data;
  logic [3:0]  w_st_mask;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_ld_val;
  logic        w_timeout;

  assign w_new_op = (r_state == S_IDLE) && (i_strobe != r_last_strobe);
  assign w_mem_op = i_mem_read || i_mem_write || i_mem_flush;
  // Busy is forced low during reset so execute sees a quiet stage.
  assign o_busy   = !i_reset && ((r_state != S_IDLE) || (w_new_op && w_mem_op));

  // Flushes ignore width; only data accesses can be misaligned.
  assign w_misalign = !i_mem_flush &&
                      ((i_mem_width == 2'd1 && i_mem_address[0]) ||
                       (i_mem_width == 2'd2 && i_mem_address[1:0] != 2'b00) ||
                       (i_mem_width == 2'd3));

  // Store data is replicated across lanes; the mask picks the live lane(s).
  always_comb begin
    w_st_data = i_rd;
    w_st_mask = 4'b1111;
    case (i_mem_width)
      2'd0: begin
        w_st_data = {4{i_rd[7:0]}};
        w_st_mask = 4'b0001 << i_mem_address[1:0];
      end
      2'd1: begin
        w_st_data = {2{i_rd[15:0]}};
        w_st_mask = i_mem_address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half from the read word and extend it.
  always_comb begin
    w_ld_byte = bus.i_bus_rdata[{r_addr_lo, 3'b000} +: 8];
    w_ld_half = bus.i_bus_rdata[{r_addr_lo[1], 4'b0000} +: 16];
    case (r_width)
      2'd0:    w_ld_val = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
      2'd1:    w_ld_val = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
      default: w_ld_val = bus.i_bus_rdata;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (r_timer == 32'(TIMEOUT - 1));

  // Next-state and output logic; every register holds unless changed below.
  always_comb begin
    w_state       = r_state;
    w_last_strobe = r_last_strobe;
    w_op_strobe   = r_op_strobe;
    w_addr_lo     = r_addr_lo;
    w_width       = r_width;
    w_signed      = r_signed;
    w_ld_rd       = r_ld_rd;
    w_timer       = r_timer;
    w_req         = r_req;
    w_rw          = r_rw;
    w_flush       = r_flush;
    w_bus_addr    = r_bus_addr;
    w_wdata       = r_wdata;
    w_wmask       = r_wmask;
    w_wb_strobe   = r_wb_strobe;
    w_wb_inst_rd  = r_wb_inst_rd;
    w_wb_rd       = r_wb_rd;
    w_fault       = r_fault;
    case (r_state)
      S_IDLE: begin
        if (w_new_op) begin
          if (!w_mem_op) begin
            w_wb_rd       = i_rd;
            w_wb_inst_rd  = i_inst_rd;
            w_wb_strobe   = !r_wb_strobe;
            w_last_strobe = i_strobe;
          end else if (w_misalign) begin
            w_fault       = 1'b1;
            w_last_strobe = i_strobe;
          end else begin
            w_op_strobe = i_strobe;
            w_addr_lo   = i_mem_address[1:0];
            w_width     = i_mem_width;
            w_signed    = i_mem_signed;
            w_ld_rd     = i_mem_inst_rd;
            w_timer     = 32'd0;
            w_req       = 1'b1;
            w_bus_addr  = {i_mem_address[31:2], 2'b00};
            w_wdata     = w_st_data;
            w_wmask     = w_st_mask;
            if (i_mem_flush) begin
              w_state = S_FLUSH;
              w_rw    = 1'b0;
              w_flush = 1'b1;
            end else if (i_mem_write) begin
              w_state = S_WRITE;
              w_rw    = 1'b1;
              w_flush = 1'b0;
            end else begin
              w_state = S_READ;
              w_rw    = 1'b0;
              w_flush = 1'b0;
            end
          end
        end
      end
      default: begin
        if (bus.i_bus_ready) begin
          w_state       = S_IDLE;
          w_req         = 1'b0;
          w_last_strobe = r_op_strobe;
          if (r_state == S_READ) begin
            w_wb_rd      = w_ld_val;
            w_wb_inst_rd = r_ld_rd;
            w_wb_strobe  = !r_wb_strobe;
          end
        end else if (w_timeout) begin
          // Abandon the access; the op is consumed without writeback.
          w_state       = S_IDLE;
          w_req         = 1'b0;
          w_fault       = 1'b1;
          w_last_strobe = r_op_strobe;
        end else begin
          w_timer = r_timer + 32'd1;
        end
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_last_strobe <= 1'b0;
      r_op_strobe   <= 1'b0;
      r_addr_lo     <= 2'd0;
      r_width       <= 2'd0;
      r_signed      <= 1'b0;
      r_ld_rd       <= 5'd0;
      r_timer       <= 32'd0;
      r_req         <= 1'b0;
      r_rw          <= 1'b0;
      r_flush       <= 1'b0;
      r_bus_addr    <= 32'd0;
      r_wdata       <= 32'd0;
      r_wmask       <= 4'd0;
      r_wb_strobe   <= 1'b0;
      r_wb_inst_rd  <= 5'd0;
      r_wb_rd       <= 32'd0;
      r_fault       <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_last_strobe <= w_last_strobe;
      r_op_strobe   <= w_op_strobe;
      r_addr_lo     <= w_addr_lo;
      r_width       <= w_width;
      r_signed      <= w_signed;
      r_ld_rd       <= w_ld_rd;
      r_timer       <= w_timer;
      r_req         <= w_req;
      r_rw          <= w_rw;
      r_flush       <= w_flush;
      r_bus_addr    <= w_bus_addr;
      r_wdata       <= w_wdata;
      r_wmask       <= w_wmask;
      r_wb_strobe   <= w_wb_strobe;
      r_wb_inst_rd  <= w_wb_inst_rd;
      r_wb_rd       <= w_wb_rd;
      r_fault       <= w_fault;
    end
  end

  assign bus.o_bus_request = r_req;
  assign bus.o_bus_rw      = r_rw;
  assign bus.o_bus_flush   = r_flush;
  assign bus.o_bus_address = r_bus_addr;
  assign bus.o_bus_wdata   = r_wdata;
  assign bus.o_bus_wmask   = r_wmask;
  assign o_wb_strobe       = r_wb_strobe;
  assign o_wb_inst_rd      = r_wb_inst_rd;
  assign o_wb_rd           = r_wb_rd;
  assign o_fault           = r_fault;

endmodule

// File: tb/tb_cpu_memory_stage.sv
// Directed bench for cpu_memory_stage (TIMEOUT=4).
module tb_cpu_memory_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [4:0]  inst_rd;
  logic [31:0] rd;
  logic        mrd, mwr, mfl, msg;
  logic [1:0]  mw;
  logic [31:0] maddr;
  logic [4:0]  mrd_dst;
  logic        busy, wbs, fault;
  logic [4:0]  wb_ird;
  logic [31:0] wb_rd;
  int          total = 0;
  int          bad = 0;
  int          cnt;
  logic        exp_wbs;

  cpu_memory_stage_if bus ();

  cpu_memory_stage #(.TIMEOUT(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_strobe(strobe), .i_inst_rd(inst_rd), .i_rd(rd),
    .i_mem_read(mrd), .i_mem_write(mwr), .i_mem_flush(mfl), .i_mem_width(mw),
    .i_mem_signed(msg), .i_mem_address(maddr), .i_mem_inst_rd(mrd_dst),
    .o_busy(busy), .bus(bus), .o_wb_strobe(wbs), .o_wb_inst_rd(wb_ird),
    .o_wb_rd(wb_rd), .o_fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op on a negedge (toggles strobe).
  task automatic issue(input logic r, input logic w, input logic f, input logic [1:0] wd,
                       input logic sg, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] ird, input logic [4:0] lrd);
    mrd = r; mwr = w; mfl = f; mw = wd; msg = sg; maddr = a; rd = d;
    inst_rd = ird; mrd_dst = lrd; strobe = ~strobe;
  endtask

  task automatic do_reset();
    rst = 1'b1; strobe = 1'b0; mrd = 0; mwr = 0; mfl = 0;
    bus.i_bus_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_wbs = 1'b0;
  endtask

  // Complete a load whose ready arrives on wait cycle 1; return nothing.
  task automatic load1(input logic [1:0] wd, input logic sg, input logic [31:0] a,
                       input logic [31:0] rdata, input logic [31:0] exp, input string tag);
    issue(1, 0, 0, wd, sg, a, 0, 0, 5'd9);
    @(negedge clk);
    bus.i_bus_rdata = rdata; bus.i_bus_ready = 1'b1;
    @(negedge clk);
    bus.i_bus_ready = 1'b0;
    exp_wbs = ~exp_wbs;
    chk({tag, "_val"}, wb_rd, exp);
    chk({tag, "_wbs"}, {31'd0, wbs}, {31'd0, exp_wbs});
  endtask

  initial begin
    strobe = 0; inst_rd = 0; rd = 0; mrd = 0; mwr = 0; mfl = 0; msg = 0; mw = 0;
    maddr = 0; mrd_dst = 0; bus.i_bus_rdata = 0; bus.i_bus_ready = 0; rst = 1;
    do_reset();
    chk("rst_req", {31'd0, bus.o_bus_request}, 0);
    chk("rst_wbs", {31'd0, wbs}, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // Pass-through
    issue(0, 0, 0, 0, 0, 0, 32'h1234, 5'd5, 0);
    #1 chk("pt_busy0", {31'd0, busy}, 0);
    @(negedge clk);
    exp_wbs = ~exp_wbs;
    chk("pt_ird", {27'd0, wb_ird}, 5);
    chk("pt_rd", wb_rd, 32'h1234);
    chk("pt_wbs", {31'd0, wbs}, {31'd0, exp_wbs});
    chk("pt_busy1", {31'd0, busy}, 0);
    issue(0, 0, 0, 0, 0, 0, 32'hCAFE0001, 5'd31, 0);
    @(negedge clk);
    exp_wbs = ~exp_wbs;
    chk("pt2_rd", wb_rd, 32'hCAFE0001);
    chk("pt2_wbs", {31'd0, wbs}, {31'd0, exp_wbs});

    // Signed byte load, ready on third wait cycle
    issue(1, 0, 0, 2'd0, 1, 32'h103, 0, 0, 5'd7);
    cnt = 0;
    #1 if (busy) cnt++;
    @(negedge clk);
    chk("ld_req", {31'd0, bus.o_bus_request}, 1);
    chk("ld_addr", bus.o_bus_address, 32'h100);
    chk("ld_rw", {31'd0, bus.o_bus_rw}, 0);
    if (busy) cnt++;
    @(negedge clk); if (busy) cnt++;
    @(negedge clk); if (busy) cnt++;
    bus.i_bus_rdata = 32'h80FFFFFF; bus.i_bus_ready = 1'b1;
    @(negedge clk);
    bus.i_bus_ready = 1'b0;
    exp_wbs = ~exp_wbs;
    chk("ld_val", wb_rd, 32'hFFFFFF80);
    chk("ld_ird", {27'd0, wb_ird}, 7);
    chk("ld_wbs", {31'd0, wbs}, {31'd0, exp_wbs});
    chk("ld_busy_cnt", cnt, 4);
    chk("ld_busy_end", {31'd0, busy}, 0);
    chk("ld_req_end", {31'd0, bus.o_bus_request}, 0);

    load1(2'd1, 0, 32'h102, 32'h87654321, 32'h00008765, "lhu");
    load1(2'd1, 1, 32'h100, 32'h87659321, 32'hFFFF9321, "lh");
    load1(2'd0, 0, 32'h101, 32'h0000A500, 32'h000000A5, "lbu");
    load1(2'd2, 1, 32'h104, 32'hDEADBEEF, 32'hDEADBEEF, "lw");

    // Half store
    issue(0, 1, 0, 2'd1, 0, 32'h202, 32'h0000ABCD, 5'd3, 0);
    @(negedge clk);
    chk("sh_wdata", bus.o_bus_wdata, 32'hABCDABCD);
    chk("sh_wmask", {28'd0, bus.o_bus_wmask}, 32'hC);
    chk("sh_rw", {31'd0, bus.o_bus_rw}, 1);
    chk("sh_addr", bus.o_bus_address, 32'h200);
    bus.i_bus_ready = 1'b1;
    @(negedge clk);
    bus.i_bus_ready = 1'b0;
    chk("sh_wbs", {31'd0, wbs}, {31'd0, exp_wbs});
    chk("sh_req", {31'd0, bus.o_bus_request}, 0);
    chk("sh_busy", {31'd0, busy}, 0);

    // Byte store lane 1
    issue(0, 1, 0, 2'd0, 0, 32'h1, 32'h1234565A, 0, 0);
    @(negedge clk);
    chk("sb_wdata", bus.o_bus_wdata, 32'h5A5A5A5A);
    chk("sb_wmask", {28'd0, bus.o_bus_wmask}, 32'h2);
    bus.i_bus_ready = 1'b1;
    @(negedge clk);
    bus.i_bus_ready = 1'b0;

    // Flush beats write and read
    issue(1, 1, 1, 2'd2, 0, 32'h47, 0, 0, 0);
    @(negedge clk);
    chk("fl_flush", {31'd0, bus.o_bus_flush}, 1);
    chk("fl_rw", {31'd0, bus.o_bus_rw}, 0);
    chk("fl_addr", bus.o_bus_address, 32'h44);
    bus.i_bus_ready = 1'b1;
    @(negedge clk);
    bus.i_bus_ready = 1'b0;
    chk("fl_wbs", {31'd0, wbs}, {31'd0, exp_wbs});

    // Misaligned word load
    issue(1, 0, 0, 2'd2, 0, 32'h301, 0, 0, 5'd4);
    @(negedge clk);
    chk("mis_req", {31'd0, bus.o_bus_request}, 0);
    chk("mis_fault", {31'd0, fault}, 1);
    chk("mis_wbs", {31'd0, wbs}, {31'd0, exp_wbs});
    chk("mis_busy", {31'd0, busy}, 0);
    issue(0, 0, 0, 0, 0, 0, 32'h77, 5'd2, 0);
    @(negedge clk);
    exp_wbs = ~exp_wbs;
    chk("mis_pt_rd", wb_rd, 32'h77);
    chk("mis_sticky", {31'd0, fault}, 1);
    do_reset();
    chk("mis_clr", {31'd0, fault}, 0);

    // Timeout after 4 wait cycles
    issue(1, 0, 0, 2'd2, 0, 32'h400, 0, 0, 5'd6);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 20 && bus.o_bus_request; i++) begin
      cnt++;
      @(negedge clk);
    end
    chk("to_cycles", cnt, 4);
    chk("to_fault", {31'd0, fault}, 1);
    chk("to_busy", {31'd0, busy}, 0);
    bus.i_bus_ready = 1'b1;
    @(negedge clk);
    bus.i_bus_ready = 1'b0;
    chk("to_late_wbs", {31'd0, wbs}, {31'd0, exp_wbs});
    chk("to_late_req", {31'd0, bus.o_bus_request}, 0);

    // Reset during load wait
    do_reset();
    issue(1, 0, 0, 2'd2, 0, 32'h500, 0, 0, 5'd8);
    @(negedge clk);
    chk("rw_req1", {31'd0, bus.o_bus_request}, 1);
    rst = 1'b1; strobe = 1'b0; mrd = 1'b0;
    @(negedge clk);
    chk("rw_req0", {31'd0, bus.o_bus_request}, 0);
    chk("rw_busy", {31'd0, busy}, 0);
    chk("rw_wbs", {31'd0, wbs}, 0);
    rst = 1'b0;
    bus.i_bus_rdata = 32'h11111111; bus.i_bus_ready = 1'b1;
    @(negedge clk);
    bus.i_bus_ready = 1'b0;
    @(negedge clk);
    chk("rw_late_wbs", {31'd0, wbs}, 0);
    chk("rw_late_rd", wb_rd, 0);
    chk("rw_late_busy", {31'd0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
